// File: rtl/iter_colour_mapper.sv
// Iteration-count to RGB colour mapper with raster framing (sof/eol) and frame counting.
// Two registered valid/ready stages; full throughput under a continuously ready sink.
module iter_colour_mapper #(
  parameter int unsigned WIDTH    = 640,
  parameter int unsigned HEIGHT   = 480,
  parameter int unsigned ITER_W   = 16,
  parameter int unsigned MAX_ITER = 255
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ITER_W-1:0] in_iter,
  input  logic              in_first,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              sof,
  output logic              eol,
  output logic              valid,
  input  logic              ready,
  output logic              frame_done,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] XLast = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YLast = YW'(HEIGHT - 1);

  // Raster position of the next pixel to be accepted
  logic [XW-1:0] x_q, x_d, tag_x;
  logic [YW-1:0] y_q, y_d, tag_y;

  // Stage 1: raw iteration count plus framing flags
  logic              s1_valid_q, s1_valid_d;
  logic [ITER_W-1:0] s1_iter_q;
  logic              s1_sof_q, s1_eol_q, s1_last_q;

  // Stage 2: mapped colour and flags, drives the outputs
  logic              s2_valid_q, s2_valid_d;
  logic [7:0]        r_q, g_q, b_q;
  logic              sof_q, eol_q, last_q;
  logic [7:0]        r_d, g_d, b_d;

  logic [15:0]       frame_cnt_q;

  logic accept;
  logic consume;
  logic s2_load;
  logic in_set;
  logic [7:0] c;

  assign consume  = s2_valid_q & ready & aresetn;
  assign s2_load  = s1_valid_q & (~s2_valid_q | ready);
  assign in_ready = aresetn & (~s1_valid_q | s2_load);
  assign accept   = in_valid & in_ready;

  // in_first retags the pixel as the frame origin; counters continue from there
  always_comb begin
    tag_x = in_first ? '0 : x_q;
    tag_y = in_first ? '0 : y_q;
    x_d   = x_q;
    y_d   = y_q;
    if (accept) begin
      if (tag_x == XLast) begin
        x_d = '0;
        y_d = (tag_y == YLast) ? '0 : tag_y + 1'b1;
      end else begin
        x_d = tag_x + 1'b1;
        y_d = tag_y;
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (accept) begin
      s1_valid_d = 1'b1;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
    end else if (consume) begin
      s2_valid_d = 1'b0;
    end
  end

  // Counts at or beyond the limit are inside the set and render black
  assign in_set = (32'(s1_iter_q) >= MAX_ITER);
  assign c      = s1_iter_q[7:0];

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (!in_set) begin
      r_d = c;
      g_d = {c[6:0], 1'b0};
      b_d = ~c;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      x_q        <= '0;
      y_q        <= '0;
      s1_valid_q <= 1'b0;
      s1_iter_q  <= '0;
      s1_sof_q   <= 1'b0;
      s1_eol_q   <= 1'b0;
      s1_last_q  <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_iter_q <= in_iter;
        s1_sof_q  <= (tag_x == '0) && (tag_y == '0);
        s1_eol_q  <= (tag_x == XLast);
        s1_last_q <= (tag_x == XLast) && (tag_y == YLast);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s2_valid_q <= 1'b0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        r_q    <= r_d;
        g_q    <= g_d;
        b_q    <= b_d;
        sof_q  <= s1_sof_q;
        eol_q  <= s1_eol_q;
        last_q <= s1_last_q;
      end
    end
  end

  assign frame_done = consume & last_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      frame_cnt_q <= '0;
    end else if (frame_done) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign r         = r_q;
  assign g         = g_q;
  assign b         = b_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign valid     = s2_valid_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_iter_colour_mapper.sv
// Scoreboard bench: two mapper instances (8x2 limit 255, 8x4 limit 1000) share one input stream;
// a driver pushes expected pixels on accept, a monitor pops and compares on consume.
module tb_iter_colour_mapper;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic        aresetn;
  logic [15:0] in_iter;
  logic        in_first, in_valid, ready;

  logic        in_ready_a, sof_a, eol_a, valid_a, frame_done_a;
  logic [7:0]  r_a, g_a, b_a;
  logic [15:0] frame_cnt_a;
  logic        in_ready_b, sof_b, eol_b, valid_b, frame_done_b;
  logic [7:0]  r_b, g_b, b_b;
  logic [15:0] frame_cnt_b;

  iter_colour_mapper #(.WIDTH(8), .HEIGHT(2), .ITER_W(16), .MAX_ITER(255)) dut_a (
    .aclk(aclk), .aresetn(aresetn), .in_iter(in_iter), .in_first(in_first),
    .in_valid(in_valid), .in_ready(in_ready_a), .r(r_a), .g(g_a), .b(b_a),
    .sof(sof_a), .eol(eol_a), .valid(valid_a), .ready(ready),
    .frame_done(frame_done_a), .frame_cnt(frame_cnt_a)
  );

  iter_colour_mapper #(.WIDTH(8), .HEIGHT(4), .ITER_W(16), .MAX_ITER(1000)) dut_b (
    .aclk(aclk), .aresetn(aresetn), .in_iter(in_iter), .in_first(in_first),
    .in_valid(in_valid), .in_ready(in_ready_b), .r(r_b), .g(g_b), .b(b_b),
    .sof(sof_b), .eol(eol_b), .valid(valid_b), .ready(ready),
    .frame_done(frame_done_b), .frame_cnt(frame_cnt_b)
  );

  typedef struct packed {
    logic [23:0] rgb_a;
    logic [23:0] rgb_b;
    logic        sof_a, sof_b, eol, last_a, last_b, lat;
    logic [31:0] cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] cyc = 0;
  int          mx = 0, mya = 0, myb = 0;
  int          fc_a = 0, fc_b = 0;
  int          pulses_a = 0, pulses_b = 0;
  bit          hand_en = 0, lat_en = 0;
  logic [23:0] hand_a, hand_b;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] colour(input logic [15:0] it, input int unsigned lim);
    logic [7:0] c;
    c = it[7:0];
    if (32'(it) >= lim) return 24'h0;
    return {c, c[6:0], 1'b0, ~c};
  endfunction

  task automatic push_model(input logic [15:0] it, input bit f);
    exp_t e;
    int tx, tya, tyb;
    tx  = f ? 0 : mx;
    tya = f ? 0 : mya;
    tyb = f ? 0 : myb;
    e.rgb_a  = hand_en ? hand_a : colour(it, 255);
    e.rgb_b  = hand_en ? hand_b : colour(it, 1000);
    e.sof_a  = (tx == 0) && (tya == 0);
    e.sof_b  = (tx == 0) && (tyb == 0);
    e.eol    = (tx == 7);
    e.last_a = (tx == 7) && (tya == 1);
    e.last_b = (tx == 7) && (tyb == 3);
    e.lat    = lat_en;
    e.cyc    = cyc;
    if (tx == 7) begin
      mx  = 0;
      mya = (tya == 1) ? 0 : tya + 1;
      myb = (tyb == 3) ? 0 : tyb + 1;
    end else begin
      mx  = tx + 1;
      mya = tya;
      myb = tyb;
    end
    sb.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the next one
  task automatic step(input bit v, input logic [15:0] it, input bit f, input bit rdy,
                      output bit acc);
    in_valid = v;
    in_iter  = it;
    in_first = f;
    ready    = rdy;
    @(negedge aclk);
    acc = in_valid && in_ready_a;
    if (acc) push_model(it, f);
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [15:0] it, input bit f);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    while (!acc && n < 20) begin
      step(1'b1, it, f, 1'b1, acc);
      n++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      step(1'b0, 16'h0, 1'b0, 1'b1, acc);
      n++;
    end
    step(1'b0, 16'h0, 1'b0, 1'b1, acc);
    chk("drain_empty", sb.size(), 0);
  endtask

  // Monitor: pops on every consumed pixel, and checks stalled outputs stay put
  initial begin
    exp_t        e;
    bit          held;
    logic [26:0] held_a;
    logic [23:0] held_b;
    held = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        held = 0;
      end else begin
        if (frame_done_a) pulses_a++;
        if (frame_done_b) pulses_b++;
        if (held) begin
          chk("hold_valid", {31'd0, valid_a}, 32'd1);
          chk("hold_data_a", {5'd0, r_a, g_a, b_a, sof_a, eol_a, 1'b0}, {5'd0, held_a});
          chk("hold_data_b", {8'd0, r_b, g_b, b_b}, {8'd0, held_b});
        end
        if (valid_a && ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("rgb_a", {8'd0, r_a, g_a, b_a}, {8'd0, e.rgb_a});
            chk("rgb_b", {8'd0, r_b, g_b, b_b}, {8'd0, e.rgb_b});
            chk("valid_b", {31'd0, valid_b}, 32'd1);
            chk("sof_a", {31'd0, sof_a}, {31'd0, e.sof_a});
            chk("sof_b", {31'd0, sof_b}, {31'd0, e.sof_b});
            chk("eol_a", {31'd0, eol_a}, {31'd0, e.eol});
            chk("eol_b", {31'd0, eol_b}, {31'd0, e.eol});
            chk("frame_done_a", {31'd0, frame_done_a}, {31'd0, e.last_a});
            chk("frame_done_b", {31'd0, frame_done_b}, {31'd0, e.last_b});
            chk("frame_cnt_a", {16'd0, frame_cnt_a}, fc_a);
            chk("frame_cnt_b", {16'd0, frame_cnt_b}, fc_b);
            if (e.lat) chk("latency", cyc - e.cyc, 32'd2);
            if (e.last_a) fc_a++;
            if (e.last_b) fc_b++;
          end
        end
        held   = valid_a && !ready;
        held_a = {r_a, g_a, b_a, sof_a, eol_a, 1'b0};
        held_b = {r_b, g_b, b_b};
      end
    end
  end

  task automatic reset_model();
    sb.delete();
    mx = 0; mya = 0; myb = 0;
    fc_a = 0; fc_b = 0;
  endtask

  initial begin
    bit acc;
    int n, guard;

    aresetn = 0; in_valid = 0; in_iter = 0; in_first = 0; ready = 0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst_valid", {31'd0, valid_a}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready_a}, 32'd0);
    chk("rst_rgb", {8'd0, r_a, g_a, b_a}, 32'd0);
    chk("rst_flags", {29'd0, sof_a, eol_a, frame_done_a}, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt_a}, 32'd0);
    @(posedge aclk);
    #1;
    aresetn = 1;

    // One full 8x2 frame at full rate
    for (int i = 0; i < 16; i++) begin
      lat_en = (i == 0);
      step(1'b1, 16'(i), 1'b0, 1'b1, acc);
      chk("full_rate_accept", {31'd0, acc}, 32'd1);
    end
    lat_en = 0;
    drain();
    chk("frame1_pulses_a", pulses_a, 1);
    chk("frame1_cnt_a", {16'd0, frame_cnt_a}, 32'd1);
    chk("frame1_cnt_b", {16'd0, frame_cnt_b}, 32'd0);

    // Colour mapping with hand-computed values
    hand_en = 1;
    hand_a = 24'h4182BE; hand_b = 24'h4182BE; send(16'h0041, 1'b0);
    hand_a = 24'h000000; hand_b = 24'hFFFE00; send(16'd255, 1'b0);
    hand_a = 24'h000000; hand_b = 24'h2C58D3; send(16'd300, 1'b0);
    hand_a = 24'h000000; hand_b = 24'hFFFE00; send(16'h01FF, 1'b0);
    hand_en = 0;
    drain();

    // Backpressure: ready low for 5 cycles with in_valid held high
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'(16'h80 + n), 1'b0, 1'b0, acc);
      if (acc) n++;
    end
    chk("bp_accepts", n, 2);
    chk("bp_in_ready", {31'd0, in_ready_a}, 32'd0);
    for (int i = 0; i < 6; i++) send(16'(16'h90 + i), 1'b0);
    drain();

    // in_first on the pixel that would be x=3
    guard = 0;
    while (mx != 3 && guard < 16) begin
      send(16'h0010, 1'b0);
      guard++;
    end
    send(16'h0033, 1'b1);
    for (int i = 0; i < 10; i++) send(16'(16'h20 + i), 1'b0);
    drain();

    // Reset with two pixels stalled in the pipeline
    step(1'b1, 16'h0055, 1'b0, 1'b0, acc);
    step(1'b1, 16'h0056, 1'b0, 1'b0, acc);
    in_valid = 0;
    aresetn = 0;
    reset_model();
    @(negedge aclk);
    chk("midrst_in_ready", {31'd0, in_ready_a}, 32'd0);
    @(posedge aclk);
    #1;
    chk("midrst_valid_a", {31'd0, valid_a}, 32'd0);
    chk("midrst_valid_b", {31'd0, valid_b}, 32'd0);
    chk("midrst_frame_cnt", {frame_cnt_a, frame_cnt_b}, 32'd0);
    aresetn = 1;
    send(16'h0077, 1'b0);
    drain();

    // Random valid/ready against the model, starting from a clean frame
    aresetn = 0;
    reset_model();
    @(posedge aclk);
    #1;
    aresetn = 1;
    pulses_a = 0;
    pulses_b = 0;
    n = 0;
    guard = 0;
    while (n < 2000 && guard < 20000) begin
      step(($urandom_range(0, 3) != 0), 16'($urandom_range(0, 1100)), 1'b0,
           ($urandom_range(0, 3) != 0), acc);
      if (acc) n++;
      guard++;
    end
    chk("rand_accepts", n, 2000);
    drain();
    chk("rand_pulses_a", pulses_a, 125);
    chk("rand_pulses_b", pulses_b, 62);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
